// File: rtl/vadd_float_seq.sv
// vadd_float_seq: sequencer around the single-precision float adder of the
// vadd_float kernel. Pairs the A/B operand streams, issues each pair to the
// adder's two input channels with a bounded number of operations in flight,
// and regenerates TLAST/TKEEP on the result stream before raising ap_done.
module vadd_float_seq #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int C_LEN_WIDTH        = 32,
    parameter int C_MAX_INFLIGHT     = 16
) (
    input  logic                            ap_aclk,
    input  logic                            ap_areset,
    input  logic                            ap_start,
    output logic                            ap_idle,
    output logic                            ap_ready,
    output logic                            ap_done,
    input  logic [C_LEN_WIDTH-1:0]          len,

    input  logic                            s_axis_a_tvalid,
    output logic                            s_axis_a_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_a_tdata,
    input  logic                            s_axis_b_tvalid,
    output logic                            s_axis_b_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_b_tdata,

    output logic                            m_axis_fa_tvalid,
    input  logic                            m_axis_fa_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_fa_tdata,
    output logic                            m_axis_fa_tlast,
    output logic                            m_axis_fb_tvalid,
    input  logic                            m_axis_fb_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_fb_tdata,
    output logic                            m_axis_fb_tlast,

    input  logic                            s_axis_r_tvalid,
    output logic                            s_axis_r_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_r_tdata,

    output logic                            m_axis_c_tvalid,
    input  logic                            m_axis_c_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_c_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_c_tkeep,
    output logic                            m_axis_c_tlast
);

    localparam int W  = C_AXIS_TDATA_WIDTH;
    localparam int LW = C_LEN_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic [LW-1:0]   len_r;
    logic [LW-1:0]   issue_cnt;
    logic [LW-1:0]   out_cnt;
    logic [LW-1:0]   inflight;

    // holding entry: one operand pair waiting to be handed to the adder
    logic            hold_full;
    logic            a_sent;
    logic            b_sent;
    logic [W-1:0]    hold_a;
    logic [W-1:0]    hold_b;
    logic            hold_last;

    logic            cap;
    logic            ab_fire;
    logic            fa_fire;
    logic            fb_fire;
    logic            c_fire;
    logic            a_done;
    logic            b_done;
    logic            last_issue;
    logic            last_out;

    // credit: pairs captured but not yet delivered downstream (modular)
    assign inflight   = issue_cnt - out_cnt;
    assign last_issue = (issue_cnt == len_r - LW'(1));
    assign last_out   = (out_cnt == len_r - LW'(1));

    // a pair is accepted only when both operands are present at once
    assign cap = (state == RUN) && !hold_full && (issue_cnt < len_r)
                 && (inflight < LW'(C_MAX_INFLIGHT));
    assign ab_fire         = cap && s_axis_a_tvalid && s_axis_b_tvalid;
    assign s_axis_a_tready = ab_fire;
    assign s_axis_b_tready = ab_fire;

    // each adder channel is served independently out of the holding entry
    assign m_axis_fa_tvalid = hold_full && !a_sent;
    assign m_axis_fb_tvalid = hold_full && !b_sent;
    assign m_axis_fa_tdata  = hold_a;
    assign m_axis_fb_tdata  = hold_b;
    assign m_axis_fa_tlast  = hold_last;
    assign m_axis_fb_tlast  = hold_last;
    assign fa_fire = m_axis_fa_tvalid && m_axis_fa_tready;
    assign fb_fire = m_axis_fb_tvalid && m_axis_fb_tready;
    assign a_done  = a_sent || fa_fire;
    assign b_done  = b_sent || fb_fire;

    // result stream is a straight pass-through with regenerated framing
    assign m_axis_c_tvalid = s_axis_r_tvalid;
    assign s_axis_r_tready = m_axis_c_tready;
    assign m_axis_c_tdata  = s_axis_r_tdata;
    assign m_axis_c_tkeep  = '1;
    assign m_axis_c_tlast  = last_out;
    assign c_fire = s_axis_r_tvalid && m_axis_c_tready;

    assign ap_idle  = (state == IDLE);
    assign ap_done  = (state == DONE);
    assign ap_ready = (ab_fire && last_issue)
                      || ((state == DONE) && (len_r == '0));

    // job control FSM with element counters
    always_ff @(posedge ap_aclk) begin
        if (ap_areset) begin
            state     <= IDLE;
            len_r     <= '0;
            issue_cnt <= '0;
            out_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        len_r     <= len;
                        issue_cnt <= '0;
                        out_cnt   <= '0;
                        state     <= (len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (ab_fire) issue_cnt <= issue_cnt + LW'(1);
                    if (c_fire)  out_cnt   <= out_cnt + LW'(1);
                    if (issue_cnt == len_r) state <= DRAIN;
                end
                DRAIN: begin
                    if (c_fire) out_cnt <= out_cnt + LW'(1);
                    // finish the cycle after the final result leaves
                    if ((out_cnt == len_r) || (c_fire && last_out)) state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // holding-entry occupancy and per-channel sent flags
    always_ff @(posedge ap_aclk) begin
        if (ap_areset) begin
            hold_full <= 1'b0;
            a_sent    <= 1'b0;
            b_sent    <= 1'b0;
        end else if (ab_fire) begin
            hold_full <= 1'b1;
            a_sent    <= 1'b0;
            b_sent    <= 1'b0;
        end else if (hold_full) begin
            if (a_done && b_done) begin
                hold_full <= 1'b0;
                a_sent    <= 1'b0;
                b_sent    <= 1'b0;
            end else begin
                a_sent <= a_done;
                b_sent <= b_done;
            end
        end
    end

    // holding-entry payload, loaded on capture
    always_ff @(posedge ap_aclk) begin
        if (ab_fire) begin
            hold_a    <= s_axis_a_tdata;
            hold_b    <= s_axis_b_tdata;
            hold_last <= last_issue;
        end
    end

endmodule

// File: doc/vadd_float_seq.md
Name: vadd_float_seq

Overview:
Kernel-level sequencer wrapped around the single-precision float adder IP in the vadd_float kernel.
- Accepts an element count at ap_start and pairs the incoming A and B streams element by element.
- Feeds each pair to the adder's two independent AXIS input channels and bounds the number of operations in flight.
- Regenerates TLAST/TKEEP on the result stream and asserts ap_done only after exactly len results have left the kernel.

Parameters:
C_AXIS_TDATA_WIDTH, 32, data width of every stream
C_LEN_WIDTH, 32, width of the element-count input and the internal counters
C_MAX_INFLIGHT, 16, maximum pairs issued but not yet output (holding entry included); range 2..255

Ports:
ap_aclk  in  1  clock; all logic on the rising edge
ap_areset  in  1  synchronous, active-high reset
ap_start  in  1  start request; sampled only in IDLE
ap_idle  out  1  high while in IDLE
ap_ready  out  1  1-cycle pulse when the last input pair is accepted
ap_done  out  1  1-cycle pulse when the last result is accepted downstream
len  in  C_LEN_WIDTH  number of elements; captured on the start cycle
s_axis_a_tvalid/tready/tdata  in/out/in  1/1/W  A operand stream
s_axis_b_tvalid/tready/tdata  in/out/in  1/1/W  B operand stream
m_axis_fa_tvalid/tready/tdata/tlast  out/in/out/out  1/1/W/1  to adder input A
m_axis_fb_tvalid/tready/tdata/tlast  out/in/out/out  1/1/W/1  to adder input B
s_axis_r_tvalid/tready/tdata  in/out/in  1/1/W  adder result; adder tlast is unused
m_axis_c_tvalid/tready/tdata/tkeep/tlast  out/in/out/out/out  1/1/W/W/8/1  kernel result stream

Behaviour:
Reset:
- state=IDLE; all counters, holding entry and sent flags cleared.
- ap_idle=1. ap_ready, ap_done and all tvalid outputs =0.
- Reset mid-run abandons the job; no ap_done is produced. The adder is reset separately.

FSM:
- IDLE -> RUN on ap_start; len is captured on that cycle.
- IDLE -> DONE instead when ap_start and len==0.
- RUN -> DRAIN when issue_cnt reaches len.
- DRAIN -> DONE when out_cnt reaches len.
- DONE -> IDLE after one cycle; ap_done=1 only in DONE.
- ap_start outside IDLE is ignored.

Pair capture:
- One holding entry {a, b, last}.
- Define cap = RUN & hold_empty & (issue_cnt<len) & (inflight<C_MAX_INFLIGHT).
- s_axis_a_tready = s_axis_b_tready = cap & s_axis_a_tvalid & s_axis_b_tvalid. Both streams always transfer on the same cycle; a lone valid is never consumed.
- On capture: issue_cnt+1; last = (issue_cnt==len-1).
- ap_ready pulses on the capture of the last pair. When len==0, ap_ready and ap_done pulse together in DONE.

Adder issue:
- m_axis_fa_tvalid = hold_full & ~a_sent; m_axis_fb_tvalid = hold_full & ~b_sent. Neither valid depends on any tready.
- Each channel sets its sent flag on its own handshake.
- The entry frees once both flags are set, either already set or set this cycle. Capture into the freed entry is allowed on the next cycle.
- tlast on both adder inputs = entry.last.

Result path:
- Combinational pass-through: m_axis_c_tvalid = s_axis_r_tvalid; s_axis_r_tready = m_axis_c_tready; tdata straight through.
- m_axis_c_tkeep = all ones.
- m_axis_c_tlast = (out_cnt==len-1), generated internally.
- out_cnt+1 per C handshake.

Credit:
- inflight = issue_cnt - out_cnt (C_LEN_WIDTH, modular).
- Capture and output on the same cycle: both counters update; inflight is unchanged.

Latency: a capture at cycle t presents the pair to the adder at t+1. Result timing is governed by the adder IP.

Test Plan:
- Basic run: len=4, A={1.0,2.0,3.0,4.0}, B={0.5,0.5,0.5,0.5}, no backpressure -> C={1.5,2.5,3.5,4.5} with tlast only on 4.5; one ap_ready pulse, then one ap_done pulse the cycle after the last C handshake.
- Zero length: len=0 with ap_start -> no stream tready asserted; ap_ready=ap_done=1 exactly one cycle later; ap_idle returns high.
- Credit limit: len=64, C_MAX_INFLIGHT=16, m_axis_c_tready=0 -> input tready drops after 16 captures. Releasing tready -> all 64 sums arrive in order; ap_done fires once.
- Skewed inputs: A valid 5 cycles before B, and adder fb_tready low 3 cycles while fa_tready is high -> A held until B arrives; fa sent once and fb once; no duplicated or dropped pair.
- Reset mid-run: ap_areset for 1 cycle after 3 of 8 results -> outputs return to reset values, ap_done never pulses; a new start with len=2 completes normally.
- Start while busy: ap_start pulsed again during RUN with a different len -> ignored; the original len governs tlast and ap_done.
